// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
//   arb_state_e : arbiter state, 2-bit encoding shown on the debug output
//   port_e      : identifies which port was granted most recently
//   AW_DEF/DW_DEF : default address/data widths of the processor data RAM
package dmem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    HOST = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store path and a
// host/debug port. One port is granted per cycle. The grant cycle drives the
// RAM pins from that port's fields. A read grant returns a one-cycle rvalid on
// the following cycle, aligned with the RAM's registered read data.
//
// Ports
//   Clock, reset               : rising-edge clock, async active-low reset
//   cpu_req/we/addr/wdata      : CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid        : CPU grant (this cycle), read-return strobe
//   host_req/we/addr/wdata     : host request, held until host_gnt
//   host_lock                  : host asks for back-to-back grants
//   host_gnt, host_rvalid      : host grant, read-return strobe
//   rdata                      : shared read data (= mem_rdata)
//   mem_addr/mem_wr/mem_wdata  : RAM pins, all zero outside a grant cycle
//   mem_rdata                  : RAM read data, one cycle after the address
//   arb_state                  : registered state for debug display
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int CPU_PRIORITY = 0,
  parameter int MAX_LOCK     = 4
) (
  input  logic          Clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    arb_state
);

  localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LCW-1:0] LOCK_SAT = LCW'(MAX_LOCK - 1);

  arb_state_e     state, state_nxt;
  port_e          last_grant;
  logic [LCW-1:0] lock_cnt;
  logic           host_stay;

  // A locked host keeps the RAM only while the CPU is not waiting, or while
  // its run is still short enough to bound the CPU's wait.
  assign host_stay = host_req && host_lock && (!cpu_req || (lock_cnt < LOCK_SAT));

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (cpu_req && host_req)
          state_nxt = ((CPU_PRIORITY != 0) || (last_grant == PORT_HOST)) ? CPU : HOST;
        else if (cpu_req)
          state_nxt = CPU;
        else if (host_req)
          state_nxt = HOST;
      end
      // The CPU's req during its own grant belongs to the served access, so
      // it is ignored here; the CPU can never be granted twice in a row.
      CPU:  state_nxt = host_req ? HOST : IDLE;
      HOST: begin
        if (host_stay)
          state_nxt = HOST;
        else if (cpu_req)
          state_nxt = CPU;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= PORT_HOST;   // first tie after reset goes to the CPU
      lock_cnt    <= '0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == CPU)
        last_grant <= PORT_CPU;
      else if (state_nxt == HOST)
        last_grant <= PORT_HOST;
      if ((state == HOST) && (state_nxt == HOST)) begin
        if (lock_cnt != LOCK_SAT)
          lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end
      cpu_rvalid  <= (state == CPU)  && !cpu_we;
      host_rvalid <= (state == HOST) && !host_we;
    end
  end

  // Grants and RAM pins decode straight from the state register so an async
  // reset drops mem_wr without waiting for a clock edge.
  assign cpu_gnt  = (state == CPU);
  assign host_gnt = (state == HOST);

  always_comb begin
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wr    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wr    = host_we;
      mem_wdata = host_wdata;
    end
  end

  assign rdata     = mem_rdata;
  assign arb_state = state;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the processor's single-port 256×16 data memory between the control FSM's load/store path (CPU port) and a host/debug port used for preloading and dumping memory. A registered three-state arbiter grants one port per cycle using a req/gnt handshake. It supports round-robin or fixed CPU priority, and a bounded host burst lock. The block sits between the control unit and the data RAM and drives the RAM's address, write-enable and write-data pins.

## Interface
- AW, 8: memory address width
- DW, 16: data width
- CPU_PRIORITY, 0: 0 selects round-robin on a tie; 1 makes the CPU always win a tie
- MAX_LOCK, 4: maximum consecutive host grants while cpu_req is pending; must be ≥1
- Clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with its fields until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  access performed this cycle
- cpu_rvalid  out  1  rdata holds the CPU read result
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host equivalents of the CPU inputs
- host_lock  in  1  requests back-to-back host grants
- host_gnt, host_rvalid  out  1/1  host equivalents of the CPU outputs
- rdata  out  DW  shared read data, equal to mem_rdata
- mem_addr  out  AW  RAM address
- mem_wr  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid 1 cycle after the address
- arb_state  out  2  current state, for debug display

## Operation
- States: IDLE=0, CPU=1, HOST=2. Code 3 is illegal and goes to IDLE.
- IDLE:
  - Only cpu_req → CPU. Only host_req → HOST. Neither → IDLE.
  - Both: CPU_PRIORITY=1 → CPU. Otherwise the grant goes to the port that is not last_grant.
- CPU:
  - cpu_gnt=1 for the whole cycle.
  - mem_addr=cpu_addr, mem_wr=cpu_we, mem_wdata=cpu_wdata.
  - Next state: HOST if host_req, else IDLE. cpu_req is masked this cycle, so the CPU is never granted twice in a row.
- HOST:
  - host_gnt=1; mem pins driven from the host fields.
  - Stays in HOST if host_req && host_lock && (!cpu_req || lock_cnt < MAX_LOCK-1).
  - Otherwise CPU if cpu_req, else IDLE.
- lock_cnt: increments on each HOST→HOST transition, saturates at MAX_LOCK-1, and clears on any other transition.
- last_grant: updated to the granted port on entry to CPU or HOST.
- Outside a grant cycle: mem_wr=0, mem_addr=0, mem_wdata=0, both gnt=0.
- Read return: in a grant cycle with we=0, the matching rvalid pulses for exactly 1 cycle on the next cycle, with rdata=mem_rdata. Write grants produce no rvalid.
- A requester samples gnt and deasserts req, or presents a new request, the following cycle. If req is still high after gnt, it counts as a new request.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, last_grant=HOST (so the first tie goes to the CPU), lock_cnt=0.
  - All gnt, rvalid and mem_wr at 0; mem_addr and mem_wdata at 0; arb_state=0.
  - Pending rvalid is discarded.
- Latency from IDLE: req high at edge N → gnt during cycle N+1 → read data with rvalid during cycle N+2.
- Both ports requesting continuously, round-robin: the grants alternate every cycle with no idle gap.
- Worst-case CPU wait behind a locked host is MAX_LOCK grant cycles.
- Reset asserted mid-grant: mem_wr drops to 0 immediately, with no clock edge required.
- The gnt and mem_* outputs are combinational from the registered state and the port inputs. arb_state, the rvalids and lock_cnt are registered.

## Structure
- Shared package dmem_arb_pkg holds:
  - the state enum (IDLE, CPU, HOST) with its 2-bit encoding
  - the port-ID typedef (PORT_CPU=0, PORT_HOST=1) used for last_grant
  - defaults for AW and DW
- Single module; no sub-module is warranted. The mux from the two port field sets onto the mem_* pins is inline logic.

## Test plan
- Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x12, with RAM[0x12]=0xBEEF → cpu_gnt in cycle 1, cpu_rvalid with rdata=0xBEEF in cycle 2, arb_state 0→1→0.
- cpu_req and host_req held high together, CPU_PRIORITY=0 → grant order CPU, HOST, CPU, HOST; each gnt lasts 1 cycle with no overlap.
- Same stimulus with CPU_PRIORITY=1 → CPU wins every tie out of IDLE, but CPU→HOST still alternates because the CPU is masked for the cycle after its grant.
- host_lock=1, host_req held, cpu_req raised during the first host grant, MAX_LOCK=4 → exactly 4 consecutive host_gnt, then cpu_gnt.
- Host write to 0x40 with data 0x1234, then CPU read of 0x40 → mem_wr=1 for one cycle only, then cpu_rvalid with rdata=0x1234 and host_rvalid=0 throughout.
- reset pulled low during a HOST grant with host_we=1 → mem_wr and host_gnt go to 0 asynchronously and no host_rvalid follows; after release, arb_state=0 and the first tie goes to the CPU.
